// File: rtl/fft32_reorder_tx_if.sv
// Frame-in / sample-out handshake bundle for fft32_reorder_tx.
// master = producer of frames and consumer of samples; slave = the reorder block.
interface fft32_reorder_tx_if #(parameter int N = 16);
  logic            in_valid;
  logic            in_ready;
  logic [32*N-1:0] in_frame_r;
  logic [32*N-1:0] in_frame_i;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_r;
  logic [N-1:0]    out_i;
  logic [4:0]      out_index;
  logic            out_last;

  modport master (
    output in_valid, in_frame_r, in_frame_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_index, out_last
  );

  modport slave (
    input  in_valid, in_frame_r, in_frame_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_index, out_last
  );
endinterface

// File: rtl/fft32_reorder_tx.sv
// Ping-pong unloader: captures a 32-sample bit-reversed frame in one beat, streams it in natural order.
// First sample valid the cycle after capture; out_ready low stalls outputs. FFT_REORDER_SCALE_EN adds /32 rounding.
module fft32_reorder_tx #(
  parameter int N      = 16,
  parameter int Q      = 8,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst,
  fft32_reorder_tx_if.slave bus
);

  if (Q < 0 || Q >= N) begin : g_q_range_invalid
    $error("Q must lie in [0, N)");
  end

  logic [N-1:0] r_mem_r [0:1][0:31];
  logic [N-1:0] r_mem_i [0:1][0:31];
  logic [1:0]   r_full;
  logic         r_wbank;
  logic         r_rbank;
  logic [4:0]   r_cnt;

  logic         w_cap;
  logic         w_xfer;
  logic         w_out_valid;
  logic [4:0]   w_rd_idx;
  logic [N-1:0] w_rd_r;
  logic [N-1:0] w_rd_i;
  logic [N-1:0] w_res_r;
  logic [N-1:0] w_res_i;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  assign bus.in_ready = !r_full[r_wbank] && !rst;
  assign w_out_valid  = r_full[r_rbank];
  assign w_cap        = bus.in_valid && bus.in_ready;
  assign w_xfer       = w_out_valid && bus.out_ready;

  // Banks hold no reset: a reset clears the full flags, which is enough to discard them.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int j = 0; j < 32; j++) begin
        r_mem_r[r_wbank][j] <= bus.in_frame_r[j*N +: N];
        r_mem_i[r_wbank][j] <= bus.in_frame_i[j*N +: N];
      end
    end
  end

  // A capture only targets an empty bank and a release only a full one, so both may fire together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 2'b00;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      r_cnt   <= 5'd0;
    end else begin
      if (w_cap) begin
        r_full[r_wbank] <= 1'b1;
        r_wbank         <= ~r_wbank;
      end
      if (w_xfer) begin
        if (r_cnt == 5'd31) begin
          r_full[r_rbank] <= 1'b0;
          r_rbank         <= ~r_rbank;
          r_cnt           <= 5'd0;
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  assign w_rd_idx = (BITREV != 0) ? bitrev5(r_cnt) : r_cnt;
  assign w_rd_r   = r_mem_r[r_rbank][w_rd_idx];
  assign w_rd_i   = r_mem_i[r_rbank][w_rd_idx];

`ifdef FFT_REORDER_SCALE_EN
  logic signed [N:0] w_sum_r;
  logic signed [N:0] w_sum_i;

  // One guard bit keeps (v + 16) from wrapping at the positive limit.
  assign w_sum_r = $signed({w_rd_r[N-1], w_rd_r}) + $signed((N+1)'(16));
  assign w_sum_i = $signed({w_rd_i[N-1], w_rd_i}) + $signed((N+1)'(16));
  assign w_res_r = {{4{w_sum_r[N]}}, w_sum_r[N:5]};
  assign w_res_i = {{4{w_sum_i[N]}}, w_sum_i[N:5]};
`else
  assign w_res_r = w_rd_r;
  assign w_res_i = w_rd_i;
`endif

  assign bus.out_valid = w_out_valid;
  assign bus.out_r     = w_out_valid ? w_res_r : '0;
  assign bus.out_i     = w_out_valid ? w_res_i : '0;
  assign bus.out_index = w_out_valid ? r_cnt : 5'd0;
  assign bus.out_last  = w_out_valid && (r_cnt == 5'd31);

endmodule

// File: tb/tb_fft32_reorder_tx.sv
// Bench for fft32_reorder_tx: bit-reversed and natural-order instances checked against a frame-queue model.
// Define FFT_REORDER_SCALE_EN for both RTL and bench to exercise the /32 rounding path.
module tb_fft32_reorder_tx;
  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] r;
    logic [N-1:0] i;
    logic [4:0]   k;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft32_reorder_tx_if #(.N(N)) b0 ();
  fft32_reorder_tx_if #(.N(N)) b1 ();

  fft32_reorder_tx #(.N(N), .Q(8), .BITREV(1)) u_dut (.clk(clk), .rst(rst), .bus(b0));
  fft32_reorder_tx #(.N(N), .Q(8), .BITREV(0)) u_nat (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;
  smp_t q [2][$];
  logic [N-1:0] got_r [32];
  logic         got_l [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++)
      if (((k >> b) & 1) != 0) r += 1 << (4 - b);
    return r;
  endfunction

  function automatic logic [N-1:0] model_out(input logic [N-1:0] v);
    int s;
    s = int'($signed(v));
`ifdef FFT_REORDER_SCALE_EN
    s = (s + 16) >>> 5;
`endif
    return s[N-1:0];
  endfunction

  // Model: each accepted frame becomes 32 queued samples; occupied banks = ceil(queued / 32).
  task automatic mon(input int u, input logic iv, input logic ir, input logic ov, input logic ordy,
                     input logic ol, input logic [4:0] oi, input logic [N-1:0] orr,
                     input logic [N-1:0] oii, input logic [32*N-1:0] fr, input logic [32*N-1:0] fi);
    string t;
    smp_t e;
    int idx;
    t = (u == 0) ? "rev" : "nat";
    if (rst) begin
      q[u].delete();
      chk({t, "_rst_in_ready"}, 32'(ir), 0);
      chk({t, "_rst_out_valid"}, 32'(ov), 0);
      return;
    end
    chk({t, "_in_ready"}, 32'(ir), 32'(((q[u].size() + 31) / 32) < 2));
    chk({t, "_out_valid"}, 32'(ov), 32'(q[u].size() > 0));
    if (ov && q[u].size() > 0) begin
      e = q[u][0];
      chk({t, "_out_r"}, 32'(orr), 32'(e.r));
      chk({t, "_out_i"}, 32'(oii), 32'(e.i));
      chk({t, "_out_index"}, 32'(oi), 32'(e.k));
      chk({t, "_out_last"}, 32'(ol), 32'(e.k == 5'd31));
      if (ordy) void'(q[u].pop_front());
    end else if (!ov) begin
      chk({t, "_idle_r"}, 32'(orr), 0);
      chk({t, "_idle_i"}, 32'(oii), 0);
      chk({t, "_idle_index"}, 32'(oi), 0);
      chk({t, "_idle_last"}, 32'(ol), 0);
    end
    if (iv && ir) begin
      for (int k = 0; k < 32; k++) begin
        idx = (u == 0) ? rev5(k) : k;
        e.r = model_out(fr[idx*N +: N]);
        e.i = model_out(fi[idx*N +: N]);
        e.k = 5'(k);
        q[u].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.in_valid, b0.in_ready, b0.out_valid, b0.out_ready, b0.out_last, b0.out_index,
        b0.out_r, b0.out_i, b0.in_frame_r, b0.in_frame_i);
    mon(1, b1.in_valid, b1.in_ready, b1.out_valid, b1.out_ready, b1.out_last, b1.out_index,
        b1.out_r, b1.out_i, b1.in_frame_r, b1.in_frame_i);
  end

  task automatic send(input int u, input logic [32*N-1:0] fr, input logic [32*N-1:0] fi);
    bit acc;
    acc = 1'b0;
    if (u == 0) begin b0.in_frame_r = fr; b0.in_frame_i = fi; b0.in_valid = 1'b1; end
    else        begin b1.in_frame_r = fr; b1.in_frame_i = fi; b1.in_valid = 1'b1; end
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = (u == 0) ? b0.in_ready : b1.in_ready;
      @(posedge clk);
      #1;
    end
    if (u == 0) b0.in_valid = 1'b0; else b1.in_valid = 1'b0;
    chk("send_accepted", 32'(acc), 1);
  endtask

  task automatic wait_idx(input logic [4:0] k);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (b0.out_valid && b0.out_index == k) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("wait_index_reached", 32'(hit), 1);
  endtask

  task automatic collect(input int u);
    for (int c = 0; c < 40; c++) begin
      if (u == 0 && b0.out_valid) begin got_r[b0.out_index] = b0.out_r; got_l[b0.out_index] = b0.out_last; end
      if (u == 1 && b1.out_valid) begin got_r[b1.out_index] = b1.out_r; got_l[b1.out_index] = b1.out_last; end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && (b0.out_valid || b1.out_valid); c++) begin
      @(posedge clk);
      #1;
    end
    chk("drained", 32'(b0.out_valid || b1.out_valid), 0);
  endtask

  logic [32*N-1:0] fr, fi, fr2;
  int vcount;

  initial begin
    b0.in_valid = 1'b0; b0.in_frame_r = '0; b0.in_frame_i = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_frame_r = '0; b1.in_frame_i = '0; b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_lit", 32'(b0.in_ready), 0);
    chk("rst_out_valid_lit", 32'(b0.out_valid), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_release", 32'(b0.in_ready), 1);

    // Single frame r = j, i = -j through the bit-reversing instance
    for (int j = 0; j < 32; j++) begin fr[j*N +: N] = N'(j); fi[j*N +: N] = N'(-j); end
    send(0, fr, fi);
    chk("first_beat_valid", 32'(b0.out_valid), 1);
    chk("first_beat_index", 32'(b0.out_index), 0);
    collect(0);
    chk("valid_drops_after_frame", 32'(b0.out_valid), 0);
    chk("last_not_at_30", 32'(got_l[30]), 0);
    chk("last_at_31", 32'(got_l[31]), 1);
`ifndef FFT_REORDER_SCALE_EN
    chk("bitrev_k1", 32'(got_r[1]), 16);
    chk("bitrev_k2", 32'(got_r[2]), 8);
    chk("bitrev_k3", 32'(got_r[3]), 24);
    chk("bitrev_k31", 32'(got_r[31]), 31);
`endif

    // Back-to-back frames A and B
    for (int j = 0; j < 32; j++) begin fr[j*N +: N] = N'(200 + j); fr2[j*N +: N] = N'(300 + j); end
    fi = '0;
    send(0, fr, fi);
    send(0, fr2, fi);
    chk("in_ready_low_both_full", 32'(b0.in_ready), 0);
    vcount = 0;
    for (int c = 0; c < 70; c++) begin
      if (b0.out_valid) vcount++;
      @(posedge clk);
      #1;
    end
    chk("b2b_valid_beats", 32'(vcount), 63);

    // Backpressure at k = 7
    for (int j = 0; j < 32; j++) fr[j*N +: N] = N'(j);
    send(0, fr, fi);
    wait_idx(5'd7);
    b0.out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_index", 32'(b0.out_index), 7);
    end
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_index", 32'(b0.out_index), 8);
    drain();

    // Reset pulse mid-stream at k = 12
    for (int j = 0; j < 32; j++) fr[j*N +: N] = N'(50 + j);
    send(0, fr, fi);
    wait_idx(5'd12);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(b0.out_valid), 0);
    chk("async_rst_r", 32'(b0.out_r), 0);
    chk("async_rst_index", 32'(b0.out_index), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_midrst", 32'(b0.in_ready), 1);
    send(0, fr, fi);
    chk("restart_valid", 32'(b0.out_valid), 1);
    chk("restart_index", 32'(b0.out_index), 0);
    drain();

    // Natural-order instance, r = 100 + j
    for (int j = 0; j < 32; j++) fr[j*N +: N] = N'(100 + j);
    send(1, fr, fi);
    collect(1);
`ifndef FFT_REORDER_SCALE_EN
    chk("nat_k0", 32'(got_r[0]), 100);
    chk("nat_k1", 32'(got_r[1]), 101);
    chk("nat_k31", 32'(got_r[31]), 131);
`endif
    drain();

`ifdef FFT_REORDER_SCALE_EN
    fr = '0;
    fr[0*N +: N] = 16'd48;
    fr[1*N +: N] = 16'd47;
    fr[2*N +: N] = 16'hFFD0;
    fr[3*N +: N] = 16'h7FFF;
    send(1, fr, fi);
    collect(1);
    chk("scale_48", 32'(got_r[0]), 2);
    chk("scale_47", 32'(got_r[1]), 1);
    chk("scale_m48", 32'(got_r[2]), 32'h0000FFFF);
    chk("scale_max", 32'(got_r[3]), 1024);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
